// File: rtl/mem_arbiter.sv
// Arbitrates the single main-memory block port between the icache refill path and the
// dcache refill/write-back path. The dcache wins by default, and a wait counter bounds icache starvation.
module mem_arbiter #(
    parameter int BLOCKSIZE = 4,
    parameter int MAXWAIT   = 4,
    localparam int DW       = 2 ** (BLOCKSIZE + 3),
    localparam int WCW      = $clog2(MAXWAIT + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ic_req,
    input  logic [31:0]     ic_addr,
    output logic [DW-1:0]   ic_data,
    output logic            ic_ack,
    input  logic            dc_req,
    input  logic            dc_write,
    input  logic [31:0]     dc_addr,
    input  logic [DW-1:0]   dc_wdata,
    output logic [DW-1:0]   dc_rdata,
    output logic            dc_ack,
    output logic            mem_req,
    output logic            mem_write,
    output logic [31:0]     mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ack,
    output logic [2:0]      dbg_state_o,
    output logic [WCW-1:0]  dbg_waitcnt_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BUSY_IC = 3'd1,
        BUSY_DC = 3'd2,
        DONE_IC = 3'd3,
        DONE_DC = 3'd4
    } state_t;

    // Handshakes: a requester raises req and holds it (with its address/data) until it
    // samples its ack pulse, then drops req on that same edge. Memory sees mem_req held with
    // stable address/data until it answers with mem_ack, which may come in the first cycle.

    state_t             state_q, state_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_write_q, mem_write_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [DW-1:0]      mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]      ic_data_q, ic_data_d;
    logic [DW-1:0]      dc_rdata_q, dc_rdata_d;
    logic               ic_ack_q, ic_ack_d;
    logic               dc_ack_q, dc_ack_d;
    logic [WCW-1:0]     waitcnt_q, waitcnt_d;
    logic               wait_full;
    logic               unused_addr_bits;

    assign wait_full        = (waitcnt_q == WCW'(MAXWAIT));
    assign unused_addr_bits = ^{ic_addr[BLOCKSIZE-1:0], dc_addr[BLOCKSIZE-1:0]};

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ic_data_d   = ic_data_q;
        dc_rdata_d  = dc_rdata_q;
        ic_ack_d    = 1'b0;
        dc_ack_d    = 1'b0;
        waitcnt_d   = waitcnt_q;

        case (state_q)
            IDLE: begin
                // The icache only overrides a competing dcache once it has lost MAXWAIT times.
                if (dc_req && !(ic_req && wait_full)) begin
                    state_d     = BUSY_DC;
                    mem_req_d   = 1'b1;
                    mem_write_d = dc_write;
                    mem_addr_d  = {dc_addr[31:BLOCKSIZE], {BLOCKSIZE{1'b0}}};
                    mem_wdata_d = dc_wdata;
                    if (ic_req && !wait_full) begin
                        waitcnt_d = waitcnt_q + WCW'(1);
                    end
                end else if (ic_req) begin
                    state_d     = BUSY_IC;
                    mem_req_d   = 1'b1;
                    mem_write_d = 1'b0;
                    mem_addr_d  = {ic_addr[31:BLOCKSIZE], {BLOCKSIZE{1'b0}}};
                    mem_wdata_d = '0;
                    waitcnt_d   = '0;
                end
            end
            BUSY_IC: begin
                if (mem_ack) begin
                    state_d     = DONE_IC;
                    mem_req_d   = 1'b0;
                    mem_write_d = 1'b0;
                    ic_data_d   = mem_rdata;
                    ic_ack_d    = 1'b1;
                end
            end
            BUSY_DC: begin
                if (mem_ack) begin
                    state_d     = DONE_DC;
                    mem_req_d   = 1'b0;
                    mem_write_d = 1'b0;
                    dc_ack_d    = 1'b1;
                    if (!mem_write_q) begin
                        dc_rdata_d = mem_rdata;
                    end
                end
            end
            DONE_IC: state_d = IDLE;
            DONE_DC: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A vanished icache request forfeits any accumulated waiting credit.
        if (!ic_req) begin
            waitcnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ic_data_q   <= '0;
            dc_rdata_q  <= '0;
            ic_ack_q    <= 1'b0;
            dc_ack_q    <= 1'b0;
            waitcnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ic_data_q   <= ic_data_d;
            dc_rdata_q  <= dc_rdata_d;
            ic_ack_q    <= ic_ack_d;
            dc_ack_q    <= dc_ack_d;
            waitcnt_q   <= waitcnt_d;
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_write     = mem_write_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign ic_data       = ic_data_q;
    assign dc_rdata      = dc_rdata_q;
    assign ic_ack        = ic_ack_q;
    assign dc_ack        = dc_ack_q;
    assign dbg_state_o   = state_q;
    assign dbg_waitcnt_o = waitcnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed transfers against a transaction-level model of the arbiter,
// with per-cycle output comparison, an ack scoreboard and hand-computed latency/address checks.
module tb_mem_arbiter;

    localparam int DW      = 128;
    localparam int MAXWAIT = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            ic_req, dc_req, dc_write;
    logic [31:0]     ic_addr, dc_addr;
    logic [DW-1:0]   dc_wdata;
    logic [DW-1:0]   ic_data, dc_rdata, mem_wdata;
    logic            ic_ack, dc_ack, mem_req, mem_write;
    logic [31:0]     mem_addr;
    logic [DW-1:0]   mem_rdata = '0;
    logic            mem_ack = 1'b0;
    logic [2:0]      dbg_state;
    logic [2:0]      dbg_waitcnt;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_data(ic_data), .ic_ack(ic_ack),
        .dc_req(dc_req), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_rdata(dc_rdata), .dc_ack(dc_ack),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .dbg_state_o(dbg_state), .dbg_waitcnt_o(dbg_waitcnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory responder ----------------
    // Answers mem_lat cycles after the first cycle of mem_req; mem_force holds ack high.
    logic            mem_force = 1'b0;
    int              mem_lat = 0;
    int              mem_cnt = 0;
    logic [DW-1:0]   mem_pat = '0;
    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            mem_ack = mem_force || (mem_cnt == mem_lat);
            mem_cnt++;
        end else begin
            mem_ack = mem_force;
            mem_cnt = 0;
        end
        mem_rdata = mem_pat;
    end

    // ---------------- behavioural model ----------------
    // Transfer-level view: either free, serving one owner, or in the ack/turnaround cycle.
    bit              model_on = 0;
    bit              m_busy, m_is_dc, m_wr, m_cool;
    logic            e_req, e_wr, e_ic_ack, e_dc_ack;
    logic [31:0]     e_addr;
    logic [DW-1:0]   e_wdata, e_icd, e_dcd;
    int              e_wc;
    logic [DW:0]     exp_q[$];

    always @(posedge clk) begin
        if (reset) begin
            model_on = 1;
            m_busy = 0; m_is_dc = 0; m_wr = 0; m_cool = 0;
            e_req = 0; e_wr = 0; e_ic_ack = 0; e_dc_ack = 0;
            e_addr = 0; e_wdata = 0; e_icd = 0; e_dcd = 0; e_wc = 0;
            exp_q.delete();
        end else if (model_on) begin
            e_ic_ack = 0;
            e_dc_ack = 0;
            if (m_cool) begin
                m_cool = 0;
            end else if (!m_busy) begin
                if (ic_req || dc_req) begin
                    bit give_ic;
                    give_ic = ic_req && (!dc_req || e_wc == MAXWAIT);
                    m_busy  = 1;
                    m_is_dc = !give_ic;
                    m_wr    = !give_ic && dc_write;
                    e_req   = 1;
                    e_wr    = m_wr;
                    e_addr  = ((give_ic ? ic_addr : dc_addr) >> 4) << 4;
                    e_wdata = give_ic ? '0 : dc_wdata;
                    if (give_ic) e_wc = 0;
                    else if (ic_req && e_wc < MAXWAIT) e_wc = e_wc + 1;
                end
            end else if (mem_ack) begin
                m_busy = 0;
                m_cool = 1;
                e_req  = 0;
                e_wr   = 0;
                if (m_is_dc) begin
                    e_dc_ack = 1;
                    if (!m_wr) e_dcd = mem_rdata;
                    exp_q.push_back({1'b1, e_dcd});
                end else begin
                    e_ic_ack = 1;
                    e_icd = mem_rdata;
                    exp_q.push_back({1'b0, e_icd});
                end
            end
            if (!ic_req) e_wc = 0;
        end
    end

    // ---------------- compare process + scoreboard ----------------
    always @(negedge clk) begin
        if (model_on) begin
            chk("ctrl{req,wr,ic_ack,dc_ack}", DW'({mem_req, mem_write, ic_ack, dc_ack}),
                DW'({e_req, e_wr, e_ic_ack, e_dc_ack}));
            chk("mem_addr", DW'(mem_addr), DW'(e_addr));
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("ic_data", ic_data, e_icd);
            chk("dc_rdata", dc_rdata, e_dcd);
            chk("waitcnt", DW'(dbg_waitcnt), DW'(e_wc));
            if (ic_ack || dc_ack) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_ack", DW'({ic_ack, dc_ack}), DW'(0));
                end else begin
                    logic [DW:0] item;
                    item = exp_q.pop_front();
                    chk("sb_owner_is_dc", DW'(dc_ack), DW'(item[DW]));
                    chk("sb_data", dc_ack ? dc_rdata : ic_data, item[DW-1:0]);
                end
            end
        end
    end

    // ---------------- snoops for literal checks ----------------
    logic [31:0]   rq_addr;
    logic          rq_write;
    logic [DW-1:0] rq_wdata;
    logic          snoop_prev = 1'b0;
    int            dc_ack_cnt = 0;
    always @(negedge clk) begin
        if (mem_req && !snoop_prev) begin
            rq_addr  = mem_addr;
            rq_write = mem_write;
            rq_wdata = mem_wdata;
        end
        snoop_prev = mem_req;
        if (dc_ack) dc_ack_cnt++;
    end

    // ---------------- driver tasks ----------------
    int dc_ack_at[$];
    int ic_seen_dc;
    int ic_seen_wc;

    task automatic ic_read(input logic [31:0] a, output int lat, output logic [DW-1:0] d);
        int start;
        bit got;
        @(posedge clk); #1;
        ic_req = 1; ic_addr = a; start = cyc; got = 0; lat = -1; d = '0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (ic_ack) begin
                got = 1; lat = cyc - start; d = ic_data;
                ic_seen_dc = dc_ack_at.size(); ic_seen_wc = int'(dbg_waitcnt);
            end
        end
        if (!got) chk("ic_ack_timeout", DW'(0), DW'(1));
        @(posedge clk); #1;
        ic_req = 0;
    endtask

    task automatic dc_xfer(input logic wr, input logic [31:0] a, input logic [DW-1:0] wd,
                           input int n);
        int start;
        int got;
        @(posedge clk); #1;
        dc_req = 1; dc_write = wr; dc_addr = a; dc_wdata = wd; start = cyc; got = 0;
        for (int i = 0; i < 600 && got < n; i++) begin
            @(negedge clk);
            if (dc_ack) begin
                got++;
                dc_ack_at.push_back(cyc - start);
            end
        end
        if (got < n) chk("dc_ack_timeout", DW'(got), DW'(n));
        @(posedge clk); #1;
        dc_req = 0; dc_write = 0;
    endtask

    function automatic int dc_at(input int idx);
        return (idx < dc_ack_at.size()) ? dc_ack_at[idx] : -1;
    endfunction

    // ---------------- directed tests ----------------
    initial begin
        int lat, lat2, base, acks_seen;
        logic [DW-1:0] d;
        reset = 1; ic_req = 0; ic_addr = 0; dc_req = 0; dc_write = 0; dc_addr = 0; dc_wdata = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_state", DW'(dbg_state), DW'(0));
        chk("rst_ctrl", DW'({mem_req, mem_write, ic_ack, dc_ack}), DW'(0));
        chk("rst_mem_addr", DW'(mem_addr), DW'(0));
        chk("rst_data", ic_data | dc_rdata | mem_wdata, DW'(0));
        chk("rst_waitcnt", DW'(dbg_waitcnt), DW'(0));

        // Single icache read, memory answers 3 cycles after mem_req.
        mem_lat = 3; mem_pat = {16{8'hA5}}; base = dc_ack_cnt;
        ic_read(32'h0040_0034, lat, d);
        chk("t1_latency", DW'(lat), DW'(5));
        chk("t1_data", d, {16{8'hA5}});
        chk("t1_mem_addr", DW'(rq_addr), DW'(32'h0040_0030));
        chk("t1_mem_write", DW'(rq_write), DW'(0));
        chk("t1_no_dc_ack", DW'(dc_ack_cnt - base), DW'(0));

        // Dcache write-back: read data from memory must not reach dc_rdata.
        mem_lat = 2; mem_pat = 128'hDEAD_BEEF_0BAD_F00D; base = dc_ack_cnt; dc_ack_at.delete();
        dc_xfer(1'b1, 32'h1000_001C, 128'h1234, 1);
        chk("t2_latency", DW'(dc_at(0)), DW'(4));
        chk("t2_mem_addr", DW'(rq_addr), DW'(32'h1000_0010));
        chk("t2_mem_write", DW'(rq_write), DW'(1));
        chk("t2_mem_wdata", rq_wdata, DW'(128'h1234));
        chk("t2_dc_rdata_kept", dc_rdata, DW'(0));
        chk("t2_one_ack", DW'(dc_ack_cnt - base), DW'(1));

        // Simultaneous requests with mem_ack tied high: dcache first.
        mem_force = 1; mem_pat = {8{16'h5A3C}}; dc_ack_at.delete();
        fork
            ic_read(32'h0000_1008, lat, d);
            dc_xfer(1'b0, 32'h2000_0004, '0, 1);
        join
        chk("t3_dc_latency", DW'(dc_at(0)), DW'(2));
        chk("t3_ic_latency", DW'(lat), DW'(5));
        chk("t3_ic_data", d, {8{16'h5A3C}});
        mem_force = 0;

        // Starvation: dcache holds its request for 6 transfers, icache waits.
        mem_lat = 0; mem_pat = {32{4'h9}}; dc_ack_at.delete();
        fork
            ic_read(32'h0000_2000, lat, d);
            dc_xfer(1'b0, 32'h3000_0000, '0, 6);
        join
        chk("t4_ic_latency", DW'(lat), DW'(14));
        chk("t4_dc_before_ic", DW'(ic_seen_dc), DW'(4));
        chk("t4_waitcnt_after", DW'(ic_seen_wc), DW'(0));
        chk("t4_dc5_latency", DW'(dc_at(4)), DW'(17));

        // Reset while BUSY_IC with no mem_ack, then a stray mem_ack.
        mem_lat = 20; mem_pat = {16{8'h77}};
        @(posedge clk); #1;
        ic_req = 1; ic_addr = 32'h0000_4444;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_busy_before", DW'({mem_req, dbg_state}), DW'({1'b1, 3'd1}));
        reset = 1; ic_req = 0;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("t5_state_idle", DW'(dbg_state), DW'(0));
        chk("t5_mem_req_low", DW'(mem_req), DW'(0));
        @(posedge clk); #1;
        mem_force = 1;
        @(posedge clk); #1;
        mem_force = 0;
        acks_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ic_ack || dc_ack || mem_req) acks_seen++;
        end
        chk("t5_no_activity", DW'(acks_seen), DW'(0));
        chk("t5_ic_data_unchanged", ic_data, DW'(0));

        // Zero-wait memory, back-to-back dcache reads every 3 cycles.
        mem_force = 1; mem_pat = {4{32'hC0FF_EE01}}; dc_ack_at.delete();
        dc_xfer(1'b0, 32'h3000_0040, '0, 3);
        lat2 = dc_at(2) - dc_at(1);
        chk("t6_first", DW'(dc_at(0)), DW'(2));
        chk("t6_second", DW'(dc_at(1)), DW'(5));
        chk("t6_spacing", DW'(lat2), DW'(3));
        chk("t6_data", dc_rdata, {4{32'hC0FF_EE01}});
        mem_force = 0;

        repeat (4) @(posedge clk);
        chk("sb_drained", DW'(exp_q.size()), DW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
